// File: rtl/reg_write_arbiter_if.sv
// Bundle between reg_write_arbiter, its four clients and the shared register.
// The slave side is the arbiter; the master side is the clients plus the register.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] wdata;
  logic [WIDTH-1:0]   read_port_1;
  logic [WIDTH-1:0]   write_port_1;
  logic               choice;
  logic [3:0]         ack;
  logic [1:0]         grant_id;
  logic               busy;
  logic               err;
  logic [CNT_W-1:0]   write_count;

  modport master (
    output req, wdata, read_port_1,
    input  write_port_1, choice, ack,
    input  grant_id, busy, err, write_count
  );

  modport slave (
    input  req, wdata, read_port_1,
    output write_port_1, choice, ack,
    output grant_id, busy, err, write_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the write port of a shared register,
// with one-cycle readback verify, completion ack and write counter.
module reg_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY
  } state_t;

  state_t           state;
  logic [1:0]       last_grant;
  logic [1:0]       gid_q;
  logic [WIDTH-1:0] data_q;
  logic             choice_q;
  logic [3:0]       ack_q;
  logic             busy_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             hit;
  logic [WIDTH-1:0] sel;

  // search starts just after the previous winner
  always_comb begin
    pick = last_grant;
    cand = last_grant;
    hit  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!hit && bus.req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int j = 0; j < 4; j++) begin
      if (pick == 2'(j))
        sel = bus.wdata[j*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      gid_q      <= '0;
      data_q     <= '0;
      choice_q   <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            gid_q    <= pick;
            data_q   <= sel;
            choice_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          choice_q <= 1'b0;
          ack_q    <= 4'b0001 << gid_q;
          state    <= VERIFY;
        end
        VERIFY: begin
          if (bus.read_port_1 != data_q)
            err_q <= 1'b1;
          cnt_q      <= cnt_q + CNT_W'(1);
          last_grant <= gid_q;
          ack_q      <= '0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          choice_q <= 1'b0;
          ack_q    <= '0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.write_port_1 = data_q;
  assign bus.choice       = choice_q;
  assign bus.ack          = ack_q;
  assign bus.grant_id     = gid_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.write_count  = cnt_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of a 16-bit storage register among four requesters. It drives the register's write data and write-enable (choice), then reads the register back on the following cycle to confirm the write. It acknowledges the winning requester, counts completed writes and flags readback mismatches. It sits between client logic and the register, and the register's read_port_1 feeds back into it.

Parameters:
WIDTH, 16, data width of the shared register
CNT_W, 8, width of the completed-write counter

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
req  input  4  write request, one bit per requester; held high until the matching ack
wdata  input  4*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]; held stable while req[i]=1
read_port_1  input  WIDTH  current register contents, fed back from the register
write_port_1  output  WIDTH  write data to the register
choice  output  1  register write enable
ack  output  4  one-hot, 1-cycle completion pulse to the granted requester
grant_id  output  2  index of the current or most recent grant
busy  output  1  high while in WRITE or VERIFY
err  output  1  sticky flag: a readback mismatch has occurred
write_count  output  CNT_W  number of completed writes, wraps modulo 2^CNT_W

Behaviour:
- FSM has three states: IDLE, WRITE, VERIFY. Outputs are Moore-decoded from the registered state and latched values.
- Reset (reset=0 at an edge) forces the following, whichever state is current:
  - state=IDLE, choice=0, ack=0, busy=0, err=0, write_count=0, write_port_1=0, grant_id=0.
  - last_grant=3, so requester 0 has first priority.
- IDLE:
  - If req != 0, pick the winner: search indices last_grant+1, +2, +3, +4 (mod 4) and take the first with req set.
  - Latch the winner index into grant_id and its wdata slice into the data latch, then go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE (exactly 1 cycle):
  - choice=1 and write_port_1=latched data.
  - The register captures the data on the closing edge. Next state is VERIFY.
- VERIFY (exactly 1 cycle):
  - choice=0 and ack[grant_id]=1.
  - If read_port_1 != latched data, err is set at the closing edge.
  - write_count increments at the closing edge, wrapping from 2^CNT_W-1 to 0.
  - last_grant takes grant_id. Next state is IDLE.
- Latency: a request sampled in IDLE at edge k gives choice=1 during cycle k..k+1 and ack during cycle k+1..k+2. The transaction takes 3 cycles including the IDLE sampling cycle, so throughput is at most one write per 3 cycles.
- req deasserted after the grant: the transaction still completes, and ack and the count update still occur.
- req deasserted before IDLE samples it: no grant.
- Simultaneous requests are resolved only by the round-robin order; no requester waits more than 3 other grants.
- write_port_1 holds the last latched value outside WRITE and is 0 after reset. choice is the only write qualifier.
- err clears only on reset. A mismatch does not block ack and does not trigger a retry.
- Reset during WRITE or VERIFY aborts the transaction: no ack, no count update, and choice is 0 from the next cycle.
- wdata slices of non-winning requesters are ignored. Data latched at grant is not updated if wdata changes later.

Test Plan:
1. Hold reset=0 for 2 edges with random req/wdata. Required: choice=0, ack=0, busy=0, err=0, write_count=0, write_port_1=0. Then release reset.
2. Drive req=4'b0001 with wdata[15:0]=65. Required: choice=1 for exactly one cycle with write_port_1=65, ack=4'b0001 on the following cycle, write_count=1, err=0. The bench's register model then reads 65.
3. Hold req=4'b1111 with data 16'h0011, 16'h0022, 16'h0033, 16'h0044, dropping each bit on its ack. Required: grants in order 0,1,2,3, choice pulses 3 cycles apart with matching data, write_count=4. Next, raise req=4'b1010. Required: requester 1 is granted before requester 3.
4. Use a bench register model stuck at 0 and write 241 from requester 2. Required: ack[2] still pulses, err=1 and stays 1 through later good writes, cleared only by reset.
5. Grant a write of 123, then drive reset=0 at the edge ending WRITE. Required: no ack, write_count unchanged, choice=0, state IDLE after release.
6. Perform 256 back-to-back writes from random requesters with $random data. Required: write_count wraps 255 -> 0 and every ack is one-hot and matches the grant_id order.
